// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-execute store queue with commit, cache drain and load forwarding
module store_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 32,
  parameter int MICROOP    = 5,
  parameter int ROB_TICKET = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  store_valid,
  input  logic [ADDR_BITS-1:0]  store_address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [MICROOP-1:0]    store_microop,
  input  logic [ROB_TICKET-1:0] store_ticket,
  output logic                  store_full,
  input  logic                  commit_valid,
  input  logic [ROB_TICKET-1:0] commit_ticket,
  output logic                  commit_error,
  input  logic                  flush,
  input  logic [ADDR_BITS-1:0]  frw_address,
  input  logic [MICROOP-1:0]    frw_microop,
  output logic [DATA_WIDTH-1:0] frw_data,
  output logic                  frw_valid,
  output logic                  frw_stall,
  output logic                  cache_writeback_valid,
  output logic [ADDR_BITS-1:0]  cache_wb_addr,
  output logic [DATA_WIDTH-1:0] cache_wb_data,
  output logic [MICROOP-1:0]    cache_wb_microop,
  input  logic                  cache_store_blocked,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [MICROOP-1:0] UOP_SW = MICROOP'(5'b00110);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW:0]             r_head, r_cmt, r_tail;
  logic                    r_commit_error;
  logic [ADDR_BITS-1:0]    r_addr [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data [DEPTH];
  logic [MICROOP-1:0]      r_uop  [DEPTH];
  logic [ROB_TICKET-1:0]   r_tkt  [DEPTH];

  logic [PW:0]             w_count, w_cmt_nxt, w_tail_nxt;
  logic                    w_full, w_push, w_has_uncmt, w_commit, w_cmt_err, w_drain, w_pop;
  logic                    w_hit, w_hit_word;
  logic [DATA_WIDTH-1:0]   w_hit_data;
  logic                    w_unused;

  // Queue control: occupancy, push/commit/pop qualification and next pointers.
  always_comb begin
    w_count     = r_tail - r_head;
    w_full      = (w_count == (PW+1)'(DEPTH));
    w_push      = store_valid & ~w_full & ~flush;
    w_has_uncmt = (r_cmt != r_tail);
    w_commit    = commit_valid & w_has_uncmt;
    w_cmt_err   = (commit_valid & ~w_has_uncmt) |
                  (w_commit & (r_tkt[r_cmt[PW-1:0]] != commit_ticket));
    w_drain     = (r_head != r_cmt);
    w_pop       = w_drain & ~cache_store_blocked;
    w_cmt_nxt   = r_cmt + {{PW{1'b0}}, w_commit};
    // Flush rolls tail back to the post-commit cmt, dropping any same-cycle push.
    w_tail_nxt  = flush ? w_cmt_nxt : (r_tail + {{PW{1'b0}}, w_push});
  end

  // Forwarding search: walk oldest to youngest so the last match wins; the incoming push is youngest.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_word = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < w_count) &&
          (r_addr[r_head[PW-1:0] + PW'(i)][ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
        w_hit      = 1'b1;
        w_hit_word = (r_uop[r_head[PW-1:0] + PW'(i)] == UOP_SW);
        w_hit_data = r_data[r_head[PW-1:0] + PW'(i)];
      end
    end
    if (w_push && (store_address[ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
      w_hit      = 1'b1;
      w_hit_word = (store_microop == UOP_SW);
      w_hit_data = store_data;
    end
  end

  // Pointer and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head         <= '0;
      r_cmt          <= '0;
      r_tail         <= '0;
      r_commit_error <= 1'b0;
    end else begin
      r_head <= r_head + {{PW{1'b0}}, w_pop};
      r_cmt  <= w_cmt_nxt;
      r_tail <= w_tail_nxt;
      if (w_cmt_err) r_commit_error <= 1'b1;
    end
  end

  // Entry storage; cleared on reset so the drain port reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_uop[i]  <= '0;
        r_tkt[i]  <= '0;
      end
    end else if (w_push) begin
      r_addr[r_tail[PW-1:0]] <= store_address;
      r_data[r_tail[PW-1:0]] <= store_data;
      r_uop[r_tail[PW-1:0]]  <= store_microop;
      r_tkt[r_tail[PW-1:0]]  <= store_ticket;
    end
  end

  assign store_full            = w_full;
  assign empty                 = (r_tail == r_head);
  assign commit_error          = r_commit_error;
  assign cache_writeback_valid = w_drain;
  assign cache_wb_addr         = r_addr[r_head[PW-1:0]];
  assign cache_wb_data         = r_data[r_head[PW-1:0]];
  assign cache_wb_microop      = r_uop[r_head[PW-1:0]];
  assign frw_valid             = w_hit & w_hit_word;
  assign frw_stall             = w_hit & ~w_hit_word;
  assign frw_data              = (w_hit & w_hit_word) ? w_hit_data : '0;

  // Load size and byte offset do not affect word-granular matching.
  assign w_unused = ^{frw_microop, frw_address[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  localparam logic [4:0] SW = 5'b00110;
  localparam logic [4:0] SB = 5'b01000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        store_valid;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic [4:0]  store_microop;
  logic [2:0]  store_ticket;
  logic        store_full;
  logic        commit_valid;
  logic [2:0]  commit_ticket;
  logic        commit_error;
  logic        flush;
  logic [31:0] frw_address;
  logic [4:0]  frw_microop;
  logic [31:0] frw_data;
  logic        frw_valid;
  logic        frw_stall;
  logic        cache_writeback_valid;
  logic [31:0] cache_wb_addr;
  logic [31:0] cache_wb_data;
  logic [4:0]  cache_wb_microop;
  logic        cache_store_blocked;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
    .store_microop(store_microop), .store_ticket(store_ticket), .store_full(store_full),
    .commit_valid(commit_valid), .commit_ticket(commit_ticket), .commit_error(commit_error),
    .flush(flush), .frw_address(frw_address), .frw_microop(frw_microop),
    .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
    .cache_writeback_valid(cache_writeback_valid), .cache_wb_addr(cache_wb_addr),
    .cache_wb_data(cache_wb_data), .cache_wb_microop(cache_wb_microop),
    .cache_store_blocked(cache_store_blocked), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    store_valid = 0; store_address = 0; store_data = 0; store_microop = 0; store_ticket = 0;
    commit_valid = 0; commit_ticket = 0; flush = 0; frw_address = 0; frw_microop = 0;
    cache_store_blocked = 0;
  endtask

  task automatic next();
    @(posedge clk); #1; clear_inputs(); @(negedge clk);
  endtask

  task automatic set_push(input logic [31:0] a, input logic [31:0] d, input logic [4:0] u, input logic [2:0] t);
    store_valid = 1; store_address = a; store_data = d; store_microop = u; store_ticket = t;
  endtask

  task automatic set_commit(input logic [2:0] t);
    commit_valid = 1; commit_ticket = t;
  endtask

  task automatic set_lookup(input logic [31:0] a);
    frw_address = a; frw_microop = 5'b00010;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    @(negedge clk); #1;
    check("rst_empty", empty, 1);
    check("rst_full", store_full, 0);
    check("rst_wbv", cache_writeback_valid, 0);
    check("rst_frwv", frw_valid, 0);
    check("rst_stall", frw_stall, 0);
    check("rst_err", commit_error, 0);
    check("rst_wbaddr", cache_wb_addr, 0);
    check("rst_frwdata", frw_data, 0);
    rst_n = 1;
    @(negedge clk);

    // In-order commit and drain of three word stores
    set_push(32'h100, 32'h11111111, SW, 3'd1); #1;
    check("t1_empty_pre", empty, 1);
    next();
    set_push(32'h104, 32'h22222222, SW, 3'd2); #1;
    check("t1_empty_post", empty, 0);
    next();
    set_push(32'h108, 32'h33333333, SW, 3'd3); next();
    check("t1_wbv_uncommitted", cache_writeback_valid, 0);
    set_commit(3'd1); next();
    check("t1_wbv0", cache_writeback_valid, 1);
    check("t1_addr0", cache_wb_addr, 32'h100);
    check("t1_data0", cache_wb_data, 32'h11111111);
    check("t1_uop0", cache_wb_microop, SW);
    set_commit(3'd2); next();
    check("t1_addr1", cache_wb_addr, 32'h104);
    set_commit(3'd3); next();
    check("t1_wbv2", cache_writeback_valid, 1);
    check("t1_addr2", cache_wb_addr, 32'h108);
    next();
    check("t1_empty_end", empty, 1);
    check("t1_wbv_end", cache_writeback_valid, 0);
    check("t1_err", commit_error, 0);

    // Forwarding: partial store stalls, youngest word wins, same-cycle bypass
    set_push(32'h200, 32'hAAAA5555, SW, 3'd4); next();
    set_push(32'h201, 32'h00000011, SB, 3'd5); next();
    set_lookup(32'h202); #1;
    check("t2_stall", frw_stall, 1);
    check("t2_stall_v", frw_valid, 0);
    set_commit(3'd4); next();
    set_commit(3'd5); next();
    next(); next();
    check("t2_drained", empty, 1);
    set_push(32'h200, 32'h00000022, SB, 3'd6); next();
    set_push(32'h200, 32'hCAFEF00D, SW, 3'd7); next();
    set_lookup(32'h200); #1;
    check("t2_sw_v", frw_valid, 1);
    check("t2_sw_d", frw_data, 32'hCAFEF00D);
    check("t2_sw_s", frw_stall, 0);
    set_lookup(32'h203); #1;
    check("t2_sw_off_d", frw_data, 32'hCAFEF00D);
    set_push(32'h300, 32'h00001234, SW, 3'd0); set_lookup(32'h300); #1;
    check("t2_byp_v", frw_valid, 1);
    check("t2_byp_d", frw_data, 32'h00001234);
    check("t2_byp_s", frw_stall, 0);
    next();
    set_lookup(32'h400); #1;
    check("t2_miss_v", frw_valid, 0);
    check("t2_miss_s", frw_stall, 0);
    check("t2_miss_d", frw_data, 0);
    set_commit(3'd6); next();
    set_commit(3'd7); next();
    set_commit(3'd0); next();
    next(); next();
    check("t2_empty_end", empty, 1);

    // Full, ignored push, pop-while-full, wrap-around forwarding
    for (int i = 0; i < 8; i++) begin
      set_push(32'h500 + 32'(4 * i), 32'h10000000 + 32'(i), SW, 3'(i));
      next();
    end
    check("t3_full", store_full, 1);
    set_push(32'h600, 32'h0000DEAD, SW, 3'd0); set_lookup(32'h600); #1;
    check("t3_full_byp", frw_valid, 0);
    next();
    check("t3_full_still", store_full, 1);
    set_commit(3'd0); next();
    set_commit(3'd1); set_push(32'h600, 32'h0000DEAD, SW, 3'd0); #1;
    check("t3_full_pop", store_full, 1);
    check("t3_pop_wbv", cache_writeback_valid, 1);
    check("t3_pop_addr", cache_wb_addr, 32'h500);
    next();
    check("t3_notfull", store_full, 0);
    check("t3_addr1", cache_wb_addr, 32'h504);
    set_lookup(32'h600); #1;
    check("t3_dropped", frw_valid, 0);
    next();
    set_push(32'h51C, 32'h88888888, SW, 3'd0); next();
    set_push(32'h508, 32'h0000005A, SB, 3'd1); next();
    check("t3_full_wrap", store_full, 1);
    set_lookup(32'h51C); #1;
    check("t3_wrap_v", frw_valid, 1);
    check("t3_wrap_d", frw_data, 32'h88888888);
    set_lookup(32'h50A); #1;
    check("t3_wrap_stall", frw_stall, 1);
    check("t3_wrap_stall_v", frw_valid, 0);
    set_lookup(32'h50C); #1;
    check("t3_old_d", frw_data, 32'h10000003);
    for (int i = 0; i < 8; i++) begin
      set_commit(3'(i + 2));
      next();
    end
    next(); next();
    check("t3_empty_end", empty, 1);
    check("t3_err", commit_error, 0);

    // Flush keeps committed entries; blocked drain holds stable
    for (int i = 0; i < 4; i++) begin
      set_push(32'h700 + 32'(4 * i), 32'h70000000 + 32'(i), SW, 3'(i + 2));
      next();
    end
    set_commit(3'd2); cache_store_blocked = 1; next();
    set_commit(3'd3); cache_store_blocked = 1; next();
    flush = 1; cache_store_blocked = 1;
    set_push(32'h710, 32'h71000000, SW, 3'd6); set_lookup(32'h710); #1;
    check("t4_flush_byp", frw_valid, 0);
    check("t4_flush_wbv", cache_writeback_valid, 1);
    next();
    cache_store_blocked = 1;
    set_lookup(32'h708); #1;
    check("t4_flushed_708_v", frw_valid, 0);
    check("t4_flushed_708_s", frw_stall, 0);
    set_lookup(32'h70C); #1;
    check("t4_flushed_70c", frw_valid, 0);
    set_lookup(32'h710); #1;
    check("t4_dropped_710", frw_valid, 0);
    set_lookup(32'h704); #1;
    check("t4_kept_v", frw_valid, 1);
    check("t4_kept_d", frw_data, 32'h70000001);
    check("t4_not_empty", empty, 0);
    check("t4_blk0_addr", cache_wb_addr, 32'h700);
    next();
    for (int i = 0; i < 4; i++) begin
      cache_store_blocked = 1; #1;
      check("t4_blk_wbv", cache_writeback_valid, 1);
      check("t4_blk_addr", cache_wb_addr, 32'h700);
      check("t4_blk_data", cache_wb_data, 32'h70000000);
      next();
    end
    #1;
    check("t4_rel_addr", cache_wb_addr, 32'h700);
    next();
    check("t4_pop_addr", cache_wb_addr, 32'h704);
    check("t4_pop_wbv", cache_writeback_valid, 1);
    next();
    check("t4_empty_end", empty, 1);
    check("t4_wbv_end", cache_writeback_valid, 0);

    // Commit errors, sticky until a mid-operation reset
    set_commit(3'd0); #1;
    check("t5_err_pre", commit_error, 0);
    next();
    check("t5_err_empty", commit_error, 1);
    check("t5_empty", empty, 1);
    set_push(32'h800, 32'h80000000, SW, 3'd1); next();
    check("t5_err_sticky", commit_error, 1);
    check("t5_has_entry", empty, 0);
    #2; rst_n = 0; #1;
    check("t5_rst_err", commit_error, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_wbv", cache_writeback_valid, 0);
    set_lookup(32'h800); #1;
    check("t5_rst_frw", frw_valid, 0);
    next();
    rst_n = 1;
    set_push(32'h900, 32'h90000000, SW, 3'd1); next();
    set_commit(3'd6); next();
    check("t5_err_ticket", commit_error, 1);
    check("t5_adv_wbv", cache_writeback_valid, 1);
    check("t5_adv_addr", cache_wb_addr, 32'h900);
    next();
    check("t5_empty_end", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
